ahb2apb_bridge: RTL and testbench
=================================

# ahb2apb_bridge

AHB-Lite responder that sits on the APB window (0x4000_0000–0x4FFF_FFFF) of the single-master AHB interconnect and turns each selected AHB transfer into one APB3 access. The AHB side presents as one slave: hsel, hready, hresp, hrdata. The APB side drives a single APB bus for the downstream peripheral decoder. All outputs are registered, and the bridge is a multi-state FSM with a pready timeout counter.

## Interface
Parameters:
- TIMEOUT_W, default 8: width of the APB wait counter.
- TIMEOUT, default 255: maximum ACCESS cycles without pready before the bridge forces an error. A value of 0 disables the timeout.

Ports:
- pll_core_cpuclk  in  1  clock
- pad_cpu_rst_b  in  1  reset, asynchronous, active-low
- hsel  in  1  slave select from the interconnect. When hsel=1 the cycle is a valid address phase; the interconnect gates hsel with its own arbitration.
- haddr  in  32  AHB address
- htrans  in  2  AHB transfer type; only bit 1 (NONSEQ/SEQ) starts a transfer
- hwrite  in  1  1 = write
- hsize  in  3  transfer size
- hwdata  in  32  write data, valid in the data phase
- hrdata  out  32  read data
- hready  out  1  transfer done / slave ready
- hresp  out  2  00 = OKAY, 01 = ERROR
- psel, penable, pwrite  out  1  APB control
- paddr, pwdata  out  32  APB address and write data
- prdata  in  32  APB read data
- pready, pslverr  in  1  APB3 completion and error

## Operation
- Accept condition: `accept = hsel & htrans[1] & hready`. It can only be true in IDLE or ERR2.
- When accept is true, the bridge captures haddr into paddr and hwrite into pwrite, and clears hready to 0.
- If hsize > 3'b010, no APB access is made. The bridge goes to ERR1 and gives an ERROR response.
- States and transitions:
  - IDLE: hready=1, hresp=00. On accept: write → WDATA, read → SETUP, illegal hsize → ERR1.
  - WDATA: pwdata <= hwdata. Next state SETUP.
  - SETUP: psel=1, penable=0, timer cleared. Next state ACCESS.
  - ACCESS: psel=1, penable=1, timer increments each cycle.
    - pready & !pslverr → IDLE. hready<=1, hresp<=00; on a read, hrdata<=prdata.
    - pready & pslverr → ERR1.
    - timer reaches TIMEOUT (and TIMEOUT≠0) with no pready → ERR1.
    - On every exit from ACCESS: psel<=0, penable<=0.
  - ERR1: hresp=01, hready=0. Next state ERR2 (hready<=1, hresp stays 01).
  - ERR2: hresp=01, hready=1. Behaves as IDLE for accept; hresp<=00 on exit.
- hrdata holds its last value on writes and on errors.
- paddr, pwrite and pwdata hold their values after the access ends.
- htrans = BUSY or IDLE while hsel=1 produces no access and an OKAY response, with hready staying 1.
- Reset values: hready=1, hresp=00, hrdata=0, psel=0, penable=0, paddr=0, pwrite=0, pwdata=0. State goes to IDLE and the timer to 0.
- Reset asserted mid-access drops psel/penable immediately (asynchronously). No response is owed.

## Timing
- Address phase is cycle T.
- Read: SETUP at T+1, ACCESS at T+2. With pready=1 at T+2, hready=1 and valid hrdata appear at T+3. Minimum read data phase is 3 cycles.
- Write: WDATA at T+1, SETUP at T+2, ACCESS at T+3, hready=1 at T+4.
- Each ACCESS cycle with pready=0 adds one cycle.
- APB error: ERR1 in the cycle after pready, then ERR2. That gives the two-cycle ERROR response, with hready low then high.
- Back-to-back transfers: a new address phase in the hready=1 completion cycle is accepted. psel is low for at least one cycle between accesses.

## Structure
- The shared header ahb_apb_defines.h holds:
  - HTRANS encodings;
  - HRESP_OKAY / HRESP_ERROR;
  - FSM state encodings IDLE, WDATA, SETUP, ACCESS, ERR1, ERR2 (3-bit).
- Sub-module ahb2apb_timer: TIMEOUT_W-bit counter with clear and enable inputs and an expired output.

## Test plan
- Read 0x4000_0010 with pready=1 in the first ACCESS cycle → psel at T+1, penable at T+2, hready=1 at T+3, hrdata=prdata=0xA5A5_0001, hresp=00.
- Write 0x4000_0020 with data 0x1234_5678 and pready delayed 3 cycles → paddr and pwdata stable through SETUP/ACCESS, hready=1 at T+7, hresp=00.
- Read with pready & pslverr → hresp=01 with hready=0, then hresp=01 with hready=1, then OKAY. hrdata unchanged.
- TIMEOUT=4 and pready held at 0 → ERR1 after 4 ACCESS cycles, psel drops, two-cycle ERROR response.
- hsize=3'b011 → no psel, two-cycle ERROR. htrans=BUSY with hsel=1 → hready stays 1, no APB activity.
- Read issued in the ERR2 cycle → accepted, with psel at the next cycle. Reset asserted in ACCESS → all outputs return to reset values asynchronously.

Source files
------------

// File: rtl/ahb2apb_bridge_pkg.sv
// Shared encodings for the AHB-Lite to APB3 bridge: transfer types, responses, FSM states.
package ahb2apb_bridge_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [1:0] HRESP_OKAY  = 2'b00;
    localparam logic [1:0] HRESP_ERROR = 2'b01;

    localparam logic [2:0] HSIZE_WORD = 3'b010;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        WDATA  = 3'd1,
        SETUP  = 3'd2,
        ACCESS = 3'd3,
        ERR1   = 3'd4,
        ERR2   = 3'd5
    } state_e;

    // NONSEQ and SEQ are the only transfer types that start an access.
    function automatic logic trans_active(input logic [1:0] trans);
        return (trans == HTRANS_NONSEQ) || (trans == HTRANS_SEQ);
    endfunction

    // The APB side is 32 bits wide; anything larger cannot be carried.
    function automatic logic size_legal(input logic [2:0] size);
        return size <= HSIZE_WORD;
    endfunction

endpackage

// File: rtl/ahb2apb_timer.sv
// APB wait-state counter: cleared in SETUP, counts ACCESS cycles, flags the last allowed one.
module ahb2apb_timer #(
    parameter int unsigned TIMEOUT_W = 8,
    parameter int unsigned TIMEOUT   = 255
) (
    input  logic pll_core_cpuclk,
    input  logic pad_cpu_rst_b,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expired_c
);

    localparam logic                 ENABLED = (TIMEOUT != 0);
    localparam logic [TIMEOUT_W-1:0] LAST    = TIMEOUT_W'(TIMEOUT - 1);
    localparam logic [TIMEOUT_W-1:0] ONE     = TIMEOUT_W'(1);

    logic [TIMEOUT_W-1:0] r_count;

    // Saturating so a disabled timeout never wraps into a false expiry.
    always_ff @(posedge pll_core_cpuclk or negedge pad_cpu_rst_b) begin
        if (!pad_cpu_rst_b) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_en && (r_count != '1)) begin
            r_count <= r_count + ONE;
        end
    end

    // High during the TIMEOUT-th ACCESS cycle.
    assign o_expired_c = ENABLED && i_en && (r_count == LAST);

endmodule

// File: rtl/ahb2apb_bridge.sv
// AHB-Lite slave on the APB window; converts each accepted transfer into one APB3 access.
module ahb2apb_bridge
    import ahb2apb_bridge_pkg::*;
#(
    parameter int unsigned TIMEOUT_W = 8,
    parameter int unsigned TIMEOUT   = 255
) (
    input  logic        pll_core_cpuclk,
    input  logic        pad_cpu_rst_b,
    input  logic        hsel,
    input  logic [31:0] haddr,
    input  logic [1:0]  htrans,
    input  logic        hwrite,
    input  logic [2:0]  hsize,
    input  logic [31:0] hwdata,
    output logic [31:0] hrdata,
    output logic        hready,
    output logic [1:0]  hresp,
    output logic        psel,
    output logic        penable,
    output logic        pwrite,
    output logic [31:0] paddr,
    output logic [31:0] pwdata,
    input  logic [31:0] prdata,
    input  logic        pready,
    input  logic        pslverr
);

    state_e              r_state;
    logic                r_hready;
    logic [1:0]          r_hresp;
    logic [DATA_W-1:0]   r_hrdata;
    logic                r_psel;
    logic                r_penable;
    logic                r_pwrite;
    logic [ADDR_W-1:0]   r_paddr;
    logic [DATA_W-1:0]   r_pwdata;

    logic w_accept;
    logic w_timer_clr;
    logic w_timer_en;
    logic w_expired;

    // hready is only high in IDLE and ERR2, so accept implies one of those states.
    assign w_accept    = hsel && trans_active(htrans) && r_hready;
    assign w_timer_clr = (r_state == SETUP);
    assign w_timer_en  = (r_state == ACCESS);

    ahb2apb_timer #(
        .TIMEOUT_W (TIMEOUT_W),
        .TIMEOUT   (TIMEOUT)
    ) u_timer (
        .pll_core_cpuclk (pll_core_cpuclk),
        .pad_cpu_rst_b   (pad_cpu_rst_b),
        .i_clr           (w_timer_clr),
        .i_en            (w_timer_en),
        .o_expired_c     (w_expired)
    );

    always_ff @(posedge pll_core_cpuclk or negedge pad_cpu_rst_b) begin
        if (!pad_cpu_rst_b) begin
            r_state   <= IDLE;
            r_hready  <= 1'b1;
            r_hresp   <= HRESP_OKAY;
            r_hrdata  <= '0;
            r_psel    <= 1'b0;
            r_penable <= 1'b0;
            r_pwrite  <= 1'b0;
            r_paddr   <= '0;
            r_pwdata  <= '0;
        end else begin
            case (r_state)
                IDLE, ERR2: begin
                    if (w_accept) begin
                        r_paddr  <= haddr;
                        r_pwrite <= hwrite;
                        r_hready <= 1'b0;
                        if (!size_legal(hsize)) begin
                            r_hresp <= HRESP_ERROR;
                            r_state <= ERR1;
                        end else if (hwrite) begin
                            r_hresp <= HRESP_OKAY;
                            r_state <= WDATA;
                        end else begin
                            r_hresp <= HRESP_OKAY;
                            r_psel  <= 1'b1;
                            r_state <= SETUP;
                        end
                    end else begin
                        r_hresp <= HRESP_OKAY;
                        r_state <= IDLE;
                    end
                end

                // hwdata is valid in the cycle after the address phase.
                WDATA: begin
                    r_pwdata <= hwdata;
                    r_psel   <= 1'b1;
                    r_state  <= SETUP;
                end

                SETUP: begin
                    r_penable <= 1'b1;
                    r_state   <= ACCESS;
                end

                ACCESS: begin
                    if (pready) begin
                        r_psel    <= 1'b0;
                        r_penable <= 1'b0;
                        if (pslverr) begin
                            r_hresp <= HRESP_ERROR;
                            r_state <= ERR1;
                        end else begin
                            r_hready <= 1'b1;
                            r_hresp  <= HRESP_OKAY;
                            if (!r_pwrite) begin
                                r_hrdata <= prdata;
                            end
                            r_state <= IDLE;
                        end
                    end else if (w_expired) begin
                        r_psel    <= 1'b0;
                        r_penable <= 1'b0;
                        r_hresp   <= HRESP_ERROR;
                        r_state   <= ERR1;
                    end
                end

                // First half of the two-cycle ERROR response; second half raises hready.
                ERR1: begin
                    r_hready <= 1'b1;
                    r_hresp  <= HRESP_ERROR;
                    r_state  <= ERR2;
                end

                default: begin
                    r_hready  <= 1'b1;
                    r_hresp   <= HRESP_OKAY;
                    r_psel    <= 1'b0;
                    r_penable <= 1'b0;
                    r_state   <= IDLE;
                end
            endcase
        end
    end

    assign hready  = r_hready;
    assign hresp   = r_hresp;
    assign hrdata  = r_hrdata;
    assign psel    = r_psel;
    assign penable = r_penable;
    assign pwrite  = r_pwrite;
    assign paddr   = r_paddr;
    assign pwdata  = r_pwdata;

endmodule

// File: tb/tb_ahb2apb_bridge.sv
// Randomized bench for ahb2apb_bridge: transaction-level latency/response model plus a reactive APB slave.
module tb_ahb2apb_bridge;

    localparam int unsigned TW = 4;
    localparam int unsigned TO = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        hsel = 1'b0;
    logic [31:0] haddr = '0;
    logic [1:0]  htrans = 2'b00;
    logic        hwrite = 1'b0;
    logic [2:0]  hsize = 3'b010;
    logic [31:0] hwdata = '0;
    logic [31:0] hrdata;
    logic        hready;
    logic [1:0]  hresp;
    logic        psel, penable, pwrite;
    logic [31:0] paddr, pwdata;
    logic [31:0] prdata = '0;
    logic        pready = 1'b0;
    logic        pslverr = 1'b0;

    int          n_checks = 0;
    int          n_pass = 0;
    logic [31:0] exp_hrdata = '0;
    bit          use_fixed = 1'b0;
    logic [31:0] fixed_rd = '0;

    always #5 clk = ~clk;

    ahb2apb_bridge #(.TIMEOUT_W(TW), .TIMEOUT(TO)) dut (
        .pll_core_cpuclk (clk),
        .pad_cpu_rst_b   (rst_n),
        .hsel            (hsel),
        .haddr           (haddr),
        .htrans          (htrans),
        .hwrite          (hwrite),
        .hsize           (hsize),
        .hwdata          (hwdata),
        .hrdata          (hrdata),
        .hready          (hready),
        .hresp           (hresp),
        .psel            (psel),
        .penable         (penable),
        .pwrite          (pwrite),
        .paddr           (paddr),
        .pwdata          (pwdata),
        .prdata          (prdata),
        .pready          (pready),
        .pslverr         (pslverr)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_hready"},  32'(hready),  32'd1);
        chk({tag, "_hresp"},   32'(hresp),   32'd0);
        chk({tag, "_hrdata"},  hrdata,       32'd0);
        chk({tag, "_psel"},    32'(psel),    32'd0);
        chk({tag, "_penable"}, 32'(penable), 32'd0);
        chk({tag, "_paddr"},   paddr,        32'd0);
        chk({tag, "_pwrite"},  32'(pwrite),  32'd0);
        chk({tag, "_pwdata"},  pwdata,       32'd0);
    endtask

    // Cycles with no transfer request (IDLE or BUSY, hsel random); bridge must stay ready.
    task automatic idle_cycles(input int k);
        for (int i = 0; i < k; i++) begin
            hsel   = 1'($urandom_range(0, 1));
            htrans = ($urandom_range(0, 1) != 0) ? 2'b01 : 2'b00;
            haddr  = $urandom;
            hwrite = 1'($urandom_range(0, 1));
            hsize  = 3'($urandom_range(0, 7));
            hwdata = $urandom;
            pready = 1'b0;
            pslverr = 1'b0;
            @(negedge clk);
            chk("idle_hready", 32'(hready), 32'd1);
            chk("idle_hresp",  32'(hresp),  32'd0);
            chk("idle_psel",   32'(psel),   32'd0);
            chk("idle_hrdata", hrdata,      exp_hrdata);
        end
    endtask

    // One AHB transfer starting in the current (ready) cycle; the APB slave inserts
    // 'waits' wait states and then answers with pslverr='err'.
    task automatic xfer(input bit wr, input logic [31:0] addr, input logic [31:0] wd,
                        input logic [2:0] sz, input int waits, input bit err);
        int          base, n, exp_l, cyc, acc, psel_first, pen_first;
        bit          legal, tmo, fail_exp, addr_bad, wd_bad, wr_bad;
        logic [31:0] rd_at_done;
        logic [1:0]  prev_hresp;

        legal    = (sz <= 3'd2);
        base     = wr ? 1 : 0;
        tmo      = legal && (TO != 0) && (waits >= int'(TO));
        n        = !legal ? 0 : (tmo ? int'(TO) : waits + 1);
        fail_exp = !legal || tmo || err;
        exp_l    = !legal ? 2 : (2 + base + n + (fail_exp ? 1 : 0));

        chk("addr_phase_hready", 32'(hready), 32'd1);
        hsel   = 1'b1;
        htrans = ($urandom_range(0, 1) != 0) ? 2'b11 : 2'b10;
        haddr  = addr;
        hwrite = wr;
        hsize  = sz;
        hwdata = $urandom;
        pready = 1'b0;
        pslverr = 1'b0;

        cyc = 0; acc = 0; psel_first = -1; pen_first = -1;
        addr_bad = 0; wd_bad = 0; wr_bad = 0;
        rd_at_done = '0;
        prev_hresp = 2'b11;
        while (cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) begin
                hsel   = 1'($urandom_range(0, 1));
                htrans = 2'b00;
                haddr  = $urandom;
                hwrite = 1'($urandom_range(0, 1));
                hsize  = 3'($urandom_range(0, 7));
                if (wr) hwdata = wd;
            end
            if (psel && psel_first < 0) psel_first = cyc;
            if (penable && pen_first < 0) pen_first = cyc;
            if (psel) begin
                if (paddr !== addr) addr_bad = 1;
                if (pwrite !== wr) wr_bad = 1;
                if (wr && (pwdata !== wd)) wd_bad = 1;
            end
            pready  = 1'b0;
            pslverr = 1'b0;
            prdata  = use_fixed ? fixed_rd : $urandom;
            if (psel && penable) begin
                acc++;
                if (acc > waits) begin
                    pready = 1'b1;
                    pslverr = err;
                    rd_at_done = prdata;
                end
            end
            if (hready) break;
            prev_hresp = hresp;
        end

        chk("latency",     32'(cyc),        32'(exp_l));
        chk("hresp_end",   32'(hresp),      fail_exp ? 32'd1 : 32'd0);
        chk("hresp_prev",  32'(prev_hresp), fail_exp ? 32'd1 : 32'd0);
        chk("psel_end",    32'(psel),       32'd0);
        chk("penable_end", 32'(penable),    32'd0);
        if (!fail_exp && !wr) exp_hrdata = rd_at_done;
        chk("hrdata", hrdata, exp_hrdata);
        if (legal) begin
            chk("psel_first",    32'(psel_first), 32'(1 + base));
            chk("penable_first", 32'(pen_first),  32'(2 + base));
            chk("access_cycles", 32'(acc),        32'(n));
            chk("paddr_stable",  32'(addr_bad),   32'd0);
            chk("pwrite_stable", 32'(wr_bad),     32'd0);
            if (wr) chk("pwdata_stable", 32'(wd_bad), 32'd0);
        end else begin
            chk("no_psel", 32'(psel_first), 32'hFFFF_FFFF);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got running expected finished");
        $fatal(1);
    end

    initial begin
        bit          wr, err;
        logic [31:0] addr, wd;
        logic [2:0]  sz;
        int          waits, k;

        #12;
        check_reset_values("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        use_fixed = 1'b1;
        fixed_rd  = 32'hA5A5_0001;
        xfer(1'b0, 32'h4000_0010, 32'h0, 3'b010, 0, 1'b0);
        use_fixed = 1'b0;
        chk("plan_read_hrdata", hrdata, 32'hA5A5_0001);
        xfer(1'b1, 32'h4000_0020, 32'h1234_5678, 3'b010, 3, 1'b0);
        chk("plan_write_pwdata", pwdata, 32'h1234_5678);
        xfer(1'b0, 32'h4000_0030, 32'h0, 3'b010, 1, 1'b1);
        xfer(1'b0, 32'h4000_0040, 32'h0, 3'b010, 10, 1'b0);
        xfer(1'b0, 32'h4000_0050, 32'h0, 3'b011, 0, 1'b0);
        xfer(1'b0, 32'h4000_0060, 32'h0, 3'b010, 0, 1'b0);
        idle_cycles(3);
        xfer(1'b1, 32'h4000_0064, 32'hCAFE_F00D, 3'b010, 3, 1'b0);
        xfer(1'b0, 32'h4000_0068, 32'h0, 3'b001, 4, 1'b0);

        for (int t = 0; t < 200; t++) begin
            wr    = 1'($urandom_range(0, 1));
            addr  = 32'h4000_0000 | ($urandom & 32'h0FFF_FFFC);
            wd    = $urandom;
            sz    = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
            waits = $urandom_range(0, 6);
            err   = ($urandom_range(0, 4) == 0);
            xfer(wr, addr, wd, sz, waits, err);
            idle_cycles($urandom_range(0, 2));
        end

        // Reset in the middle of an ACCESS phase.
        hsel = 1'b1; htrans = 2'b10; haddr = 32'h4000_0070; hwrite = 1'b0; hsize = 3'b010;
        pready = 1'b0; pslverr = 1'b0;
        @(negedge clk);
        hsel = 1'b0; htrans = 2'b00;
        k = 0;
        while (k < 10 && !(psel && penable)) begin
            @(negedge clk);
            k++;
        end
        chk("rst_reached_access", 32'(penable), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_values("async_reset");
        @(negedge clk);
        rst_n = 1'b1;
        exp_hrdata = '0;
        @(negedge clk);
        xfer(1'b0, 32'h4000_0074, 32'h0, 3'b010, 2, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
